result_queue: RTL and testbench

RESULT_QUEUE -- requirements
Module: result_queue

---
 rtl/result_queue.sv | 112 +++++++++++
 tb/tb_result_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/result_queue.sv
// Result queue: a circular buffer of completed execution results that requests a
// common-data-bus slot and drives the granted lane with the oldest entry.
module result_queue #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  input  logic [XLEN-1:0]      i_in_result,
  input  logic [TAG_W-1:0]     i_in_tag,
  output logic                 o_in_ready,
  output logic                 o_get_bus,
  input  logic                 i_bus_granted,
  input  logic                 i_bus_selected,
  output logic [1:0]           o_cdb_valid,
  output logic [2*XLEN-1:0]    o_cdb_result,
  output logic [2*TAG_W-1:0]   o_cdb_tag
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [XLEN-1:0]  r_mem_result [DEPTH];
  logic [TAG_W-1:0] r_mem_tag    [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_head_result;
  logic [TAG_W-1:0] w_head_tag;

  assign o_in_ready    = (r_count < FULL_COUNT) && !i_flush;
  assign o_get_bus     = (r_count != {CNT_W{1'b0}}) && !i_flush;
  assign w_push        = i_in_valid && o_in_ready;
  assign w_pop         = i_bus_granted && o_get_bus;
  assign w_head_result = r_mem_result[r_head];
  assign w_head_tag    = r_mem_tag[r_head];

  // Entry storage carries no reset: validity is defined only by the occupancy count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_result[r_tail] <= i_in_result;
      r_mem_tag[r_tail]    <= i_in_tag;
    end
  end

  // Pointer and occupancy bookkeeping; flush overrides any push or pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (i_flush) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end else begin
        r_tail <= r_tail;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end else begin
        r_head <= r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Lane drive: idle lanes stay all-zero so the bus can be wire-ORed.
  always_comb begin
    o_cdb_valid  = 2'b00;
    o_cdb_result = {(2*XLEN){1'b0}};
    o_cdb_tag    = {(2*TAG_W){1'b0}};
    if (w_pop) begin
      case (i_bus_selected)
        1'b0: begin
          o_cdb_valid            = 2'b01;
          o_cdb_result[XLEN-1:0] = w_head_result;
          o_cdb_tag[TAG_W-1:0]   = w_head_tag;
        end
        1'b1: begin
          o_cdb_valid                 = 2'b10;
          o_cdb_result[2*XLEN-1:XLEN] = w_head_result;
          o_cdb_tag[2*TAG_W-1:TAG_W]  = w_head_tag;
        end
        default: begin
          o_cdb_valid  = 2'b00;
          o_cdb_result = {(2*XLEN){1'b0}};
          o_cdb_tag    = {(2*TAG_W){1'b0}};
        end
      endcase
    end else begin
      o_cdb_valid  = 2'b00;
      o_cdb_result = {(2*XLEN){1'b0}};
      o_cdb_tag    = {(2*TAG_W){1'b0}};
    end
  end

endmodule

// File: tb/tb_result_queue.sv
// Scoreboard bench for result_queue: accepted pushes queue expected entries, a
// negedge monitor pops and checks every lane the DUT drives.
module tb_result_queue;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int DEPTH = 4;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic [XLEN-1:0]    in_result;
  logic [TAG_W-1:0]   in_tag;
  logic               in_ready;
  logic               get_bus;
  logic               bus_granted;
  logic               bus_selected;
  logic [1:0]         cdb_valid;
  logic [2*XLEN-1:0]  cdb_result;
  logic [2*TAG_W-1:0] cdb_tag;

  int n_tests = 0;
  int n_fail  = 0;
  int m_count = 0;
  logic [XLEN+TAG_W-1:0] sb_q[$];

  result_queue #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_in_valid     (in_valid),
    .i_in_result    (in_result),
    .i_in_tag       (in_tag),
    .o_in_ready     (in_ready),
    .o_get_bus      (get_bus),
    .i_bus_granted  (bus_granted),
    .i_bus_selected (bus_selected),
    .o_cdb_valid    (cdb_valid),
    .o_cdb_result   (cdb_result),
    .o_cdb_tag      (cdb_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every driven lane must carry the oldest outstanding entry.
  always @(negedge clk) begin
    logic [XLEN+TAG_W-1:0] e;
    if (cdb_valid != 2'b00) begin
      chk("lane_valid", 64'(cdb_valid), (bus_selected ? 64'h2 : 64'h1));
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 64'(cdb_valid), 64'h0);
      end else begin
        e = sb_q.pop_front();
        if (bus_selected) begin
          chk("lane1_result", 64'(cdb_result[2*XLEN-1:XLEN]), 64'(e[XLEN+TAG_W-1:TAG_W]));
          chk("lane1_tag",    64'(cdb_tag[2*TAG_W-1:TAG_W]),  64'(e[TAG_W-1:0]));
          chk("lane0_zero",   64'({cdb_result[XLEN-1:0], cdb_tag[TAG_W-1:0]}), 64'h0);
        end else begin
          chk("lane0_result", 64'(cdb_result[XLEN-1:0]), 64'(e[XLEN+TAG_W-1:TAG_W]));
          chk("lane0_tag",    64'(cdb_tag[TAG_W-1:0]),   64'(e[TAG_W-1:0]));
          chk("lane1_zero",   64'({cdb_result[2*XLEN-1:XLEN], cdb_tag[2*TAG_W-1:TAG_W]}), 64'h0);
        end
      end
    end
  end

  // One clock cycle of stimulus plus the combinational expectations from the count model.
  task automatic cyc(input logic v, input logic [XLEN-1:0] res, input logic [TAG_W-1:0] tag,
                     input logic g, input logic sel, input logic fl);
    logic exp_ready, exp_gb;
    logic [1:0] exp_valid;
    @(posedge clk);
    #1;
    in_valid = v; in_result = res; in_tag = tag;
    bus_granted = g; bus_selected = sel; flush = fl;
    #1;
    exp_ready = (m_count < DEPTH) && !fl;
    exp_gb    = (m_count > 0) && !fl;
    exp_valid = (g && exp_gb) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("get_bus",  64'(get_bus),  64'(exp_gb));
    chk("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
    if (exp_valid == 2'b00) begin
      chk("idle_zero", 64'({cdb_result, cdb_tag}), 64'h0);
    end
    if (fl) begin
      sb_q.delete();
      m_count = 0;
    end else begin
      if (v && exp_ready) begin
        sb_q.push_back({res, tag});
        m_count++;
      end
      if (g && exp_gb) begin
        m_count--;
      end
    end
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = 32'h0; in_tag = 6'd0;
    bus_granted = 1'b0; bus_selected = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_get_bus",  64'(get_bus),  64'h0);
    chk("rst_cdb",      64'({cdb_valid, cdb_result, cdb_tag}), 64'h0);
    #10;
    rst_n = 1'b1;

    // Single transfer on lane 1
    cyc(1'b1, 32'h0000_00AA, 6'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 6'd0, 1'b1, 1'b1, 1'b0);
    idle();

    // Fill to DEPTH, drop a push while full, drain in order
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'h100 + 32'(i), 6'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h109, 6'd9, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 6'd0, 1'b1, 1'(i), 1'b0);
    idle();

    // Simultaneous push and pop at count 2 across the pointer wrap
    cyc(1'b1, 32'h0000_0A10, 6'd10, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0A11, 6'd11, 1'b0, 1'b0, 1'b0);
    for (int i = 12; i <= 14; i++) cyc(1'b1, 32'h0A00 + 32'(i), 6'(i), 1'b1, 1'(i), 1'b0);
    cyc(1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 6'd0, 1'b1, 1'b1, 1'b0);
    idle();

    // Full + grant + push: pop happens, push rejected, then one slot frees up
    for (int i = 20; i <= 23; i++) cyc(1'b1, 32'hB000 + 32'(i), 6'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB024, 6'd24, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hB025, 6'd25, 1'b0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 6'd0, 1'b1, 1'(i + 1), 1'b0);
    idle();

    // Flush with count 3 and grant high
    for (int i = 30; i <= 32; i++) cyc(1'b1, 32'hC000 + 32'(i), 6'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 1'b1);
    idle();

    // Asynchronous reset mid-cycle with count 2 and a grant pending
    cyc(1'b1, 32'hD040, 6'd40, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hD041, 6'd41, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; bus_granted = 1'b1; bus_selected = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'h1);
    chk("arst_get_bus",  64'(get_bus),  64'h0);
    chk("arst_cdb",      64'({cdb_valid, cdb_result, cdb_tag}), 64'h0);
    sb_q.delete();
    m_count = 0;
    bus_granted = 1'b0;
    #10;
    rst_n = 1'b1;
    cyc(1'b1, 32'hE007, 6'd7, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 1'b0);
    idle();
    idle();

    chk("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
